// File: rtl/mult_div_inverse_pkg.sv
// Shared types and helpers for the iterative restoring divider.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mult_div_inverse_pkg;

    // Widest divisor the shared step function handles; narrower dividers zero-extend into it.
    localparam int DIV_MAX_B   = 64;
    localparam int DEF_A_WIDTH = 64;
    localparam int CNT_W       = $clog2(DEF_A_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [DIV_MAX_B-1:0] rem;
        logic                 qbit;
    } div_step_t;

    // Iteration counter width for a given quotient width.
    function automatic int cnt_width(input int a);
        return $clog2(a + 1);
    endfunction

    // One restoring step: shift the next dividend bit into the partial remainder
    // and subtract the divisor when it fits. The compare is one bit wider than the
    // divisor; the difference fits back in divisor width because rem < d on entry.
    function automatic div_step_t div_step(input logic [DIV_MAX_B-1:0] rem,
                                           input logic                 nbit,
                                           input logic [DIV_MAX_B-1:0] d);
        logic [DIV_MAX_B:0] t;
        div_step_t          res;
        t = {rem, nbit};
        if (t >= {1'b0, d}) begin
            res.rem  = t[DIV_MAX_B-1:0] - d;
            res.qbit = 1'b1;
        end else begin
            res.rem  = t[DIV_MAX_B-1:0];
            res.qbit = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/mult_div_inverse_if.sv
// Request/response bundle for the divider: dividend/divisor in, quotient/remainder/flags out.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the request and the response side.
interface mult_div_inverse_if #(
    parameter int inst_a_width = 64,
    parameter int inst_b_width = 64
);
    logic                                 in_valid;
    logic                                 in_ready;
    logic [inst_a_width+inst_b_width-1:0] c;
    logic [inst_b_width-1:0]              b;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [inst_a_width-1:0]              q;
    logic [inst_b_width-1:0]              r;
    logic                                 div_zero;
    logic                                 ovf;

    modport master (
        output in_valid, c, b, out_ready,
        input  in_ready, out_valid, q, r, div_zero, ovf
    );

    modport slave (
        input  in_valid, c, b, out_ready,
        output in_ready, out_valid, q, r, div_zero, ovf
    );
endinterface

// File: rtl/mult_div_inverse.sv
// Radix-2 restoring unsigned divider: (A+B)-bit dividend / B-bit divisor -> A-bit quotient, B-bit remainder.
// Latency: A+1 cycles accept-to-out_valid for a normal divide, 1 cycle for divide-by-zero or overflow.
// Backpressure: in_ready only while idle (no overlap); result held in DONE until out_ready.
module mult_div_inverse
    import mult_div_inverse_pkg::*;
#(
    parameter int inst_a_width = 64,   // quotient width, >= 2
    parameter int inst_b_width = 64    // divisor/remainder width, <= DIV_MAX_B
) (
    input  logic                  clk,
    input  logic                  rst,
    mult_div_inverse_if.slave     bus
);

    localparam int CW = cnt_width(inst_a_width);
    localparam logic [CW-1:0] LAST_ITER = CW'(inst_a_width - 1);

    state_t                  state;
    logic [CW-1:0]           cnt;
    // Partial remainder is kept at divisor width: it is always below the divisor,
    // so the extra bit of the B+1-bit subtractor only exists inside the step compare.
    logic [inst_b_width-1:0] rem;
    logic [inst_a_width-1:0] shreg;
    logic [inst_b_width-1:0] dvsr;
    div_step_t               step;

    // Single subtractor: next partial remainder and quotient bit from the current state.
    always_comb begin
        step = div_step(DIV_MAX_B'(rem), shreg[inst_a_width-1], DIV_MAX_B'(dvsr));
    end

    // Control FSM plus datapath registers; all outputs come straight from flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            rem           <= '0;
            shreg         <= '0;
            dvsr          <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.q         <= '0;
            bus.r         <= '0;
            bus.div_zero  <= 1'b0;
            bus.ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        dvsr         <= bus.b;
                        cnt          <= '0;
                        bus.in_ready <= 1'b0;
                        if (bus.b == '0) begin
                            // Divide by zero: report low dividend half as remainder.
                            state         <= DONE;
                            bus.out_valid <= 1'b1;
                            bus.q         <= '1;
                            bus.r         <= bus.c[inst_b_width-1:0];
                            bus.div_zero  <= 1'b1;
                            bus.ovf       <= 1'b0;
                        end else if (bus.c[inst_a_width+inst_b_width-1:inst_a_width] >= bus.b) begin
                            // Quotient would need more than A bits: saturate and flag.
                            state         <= DONE;
                            bus.out_valid <= 1'b1;
                            bus.q         <= '1;
                            bus.r         <= '0;
                            bus.div_zero  <= 1'b0;
                            bus.ovf       <= 1'b1;
                        end else begin
                            state <= RUN;
                            rem   <= bus.c[inst_a_width+inst_b_width-1:inst_a_width];
                            shreg <= bus.c[inst_a_width-1:0];
                        end
                    end
                end
                RUN: begin
                    // Dividend bits leave the top of shreg while quotient bits enter at the bottom.
                    rem   <= step.rem[inst_b_width-1:0];
                    shreg <= {shreg[inst_a_width-2:0], step.qbit};
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        // Final iteration publishes its result directly, saving a cycle.
                        state         <= DONE;
                        bus.out_valid <= 1'b1;
                        bus.q         <= {shreg[inst_a_width-2:0], step.qbit};
                        bus.r         <= step.rem[inst_b_width-1:0];
                        bus.div_zero  <= 1'b0;
                        bus.ovf       <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_inverse.sv
// Self-checking bench for mult_div_inverse with a queue scoreboard of expected results.
// Latency: checks A+1 normal and 1-cycle flag latency.
// Backpressure: exercises held out_ready and in_valid while busy.
module tb_mult_div_inverse;

    localparam int A = 64;
    localparam int B = 64;

    typedef struct packed {
        logic [A-1:0] q;
        logic [B-1:0] r;
        logic         dz;
        logic         ovf;
    } res_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   passes = 0;
    res_t sb[$];

    mult_div_inverse_if #(.inst_a_width(A), .inst_b_width(B)) bus ();

    mult_div_inverse #(.inst_a_width(A), .inst_b_width(B)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    // Present one request, wait for acceptance and then for out_valid (sampled on negedges).
    task automatic run_op(input logic [A+B-1:0] cv, input logic [B-1:0] bv,
                          output int lat, output bit to);
        int guard;
        guard = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.c        = cv;
        bus.b        = bv;
        while (!bus.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.c        = ~cv;
        bus.b        = ~bv;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        to = (guard >= 200) || !bus.out_valid;
    endtask

    // Capture the presented result and complete the output handshake.
    task automatic take_result(output res_t got);
        got.q   = bus.q;
        got.r   = bus.r;
        got.dz  = bus.div_zero;
        got.ovf = bus.ovf;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.c         = '0;
        bus.b         = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.q !== '0 || bus.r !== '0 ||
            bus.div_zero !== 1'b0 || bus.ovf !== 1'b0) begin
            $display("FAIL reset_outputs: got ov=%b q=%h r=%h dz=%b ovf=%b, want all zero",
                     bus.out_valid, bus.q, bus.r, bus.div_zero, bus.ovf);
        end else passes++;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready: got %b, want 1", bus.in_ready);
        end else passes++;
    endtask

    task automatic test_normal();
        int   lat;
        bit   to;
        res_t got, exp;
        logic [A+B-1:0] cv;
        cv = 128'd12345 * 128'd678 + 128'd9;
        sb.push_back('{q: 64'd12345, r: 64'd9, dz: 1'b0, ovf: 1'b0});
        run_op(cv, 64'd678, lat, to);
        checks++;
        if (to || lat != A + 1) begin
            $display("FAIL normal_latency: got %0d (timeout=%0d), want %0d", lat, to, A + 1);
        end else passes++;
        take_result(got);
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
            $display("FAIL normal_result: got q=%h r=%h dz=%b ovf=%b, want q=%h r=%h dz=%b ovf=%b",
                     got.q, got.r, got.dz, got.ovf, exp.q, exp.r, exp.dz, exp.ovf);
        end else passes++;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            $display("FAIL normal_release: got ov=%b ir=%b, want ov=0 ir=1", bus.out_valid, bus.in_ready);
        end else passes++;
    endtask

    task automatic test_ovf();
        int   lat;
        bit   to;
        res_t got, exp;
        logic [A+B-1:0] cv;
        cv = 128'h5 << 64;
        sb.push_back('{q: '1, r: '0, dz: 1'b0, ovf: 1'b1});
        run_op(cv, 64'd3, lat, to);
        checks++;
        if (to || lat != 1) begin
            $display("FAIL ovf_latency: got %0d (timeout=%0d), want 1", lat, to);
        end else passes++;
        take_result(got);
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
            $display("FAIL ovf_result: got q=%h r=%h dz=%b ovf=%b, want q=%h r=%h dz=%b ovf=%b",
                     got.q, got.r, got.dz, got.ovf, exp.q, exp.r, exp.dz, exp.ovf);
        end else passes++;
    endtask

    task automatic test_div_zero();
        int   lat;
        bit   to;
        res_t got, exp;
        sb.push_back('{q: '1, r: 64'h1234, dz: 1'b1, ovf: 1'b0});
        run_op(128'h1234, 64'd0, lat, to);
        checks++;
        if (to || lat != 1) begin
            $display("FAIL dz_latency: got %0d (timeout=%0d), want 1", lat, to);
        end else passes++;
        take_result(got);
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
            $display("FAIL dz_result: got q=%h r=%h dz=%b ovf=%b, want q=%h r=%h dz=%b ovf=%b",
                     got.q, got.r, got.dz, got.ovf, exp.q, exp.r, exp.dz, exp.ovf);
        end else passes++;
        // Largest non-overflowing quotient with a divisor of one.
        sb.push_back('{q: '1, r: '0, dz: 1'b0, ovf: 1'b0});
        run_op({64'd0, {64{1'b1}}}, 64'd1, lat, to);
        checks++;
        if (to || lat != A + 1) begin
            $display("FAIL div1_latency: got %0d (timeout=%0d), want %0d", lat, to, A + 1);
        end else passes++;
        take_result(got);
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
            $display("FAIL div1_result: got q=%h r=%h dz=%b ovf=%b, want q=%h r=%h dz=%b ovf=%b",
                     got.q, got.r, got.dz, got.ovf, exp.q, exp.r, exp.dz, exp.ovf);
        end else passes++;
    endtask

    task automatic test_hold();
        int   lat;
        bit   to;
        res_t got, exp;
        logic [A-1:0] q0;
        logic [B-1:0] r0;
        sb.push_back('{q: 64'd1000, r: 64'd5, dz: 1'b0, ovf: 1'b0});
        run_op(128'd1000 * 128'd77 + 128'd5, 64'd77, lat, to);
        checks++;
        if (to) begin
            $display("FAIL hold_timeout: got no out_valid, want out_valid");
        end else passes++;
        q0 = bus.q;
        r0 = bus.r;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                bus.in_valid = 1'b1;
                bus.c        = 128'd999;
                bus.b        = 64'd1;
            end
            if (i == 5) bus.in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (bus.q !== q0 || bus.r !== r0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                $display("FAIL hold_stable[%0d]: got q=%h r=%h ir=%b ov=%b, want q=%h r=%h ir=0 ov=1",
                         i, bus.q, bus.r, bus.in_ready, bus.out_valid, q0, r0);
            end else passes++;
        end
        take_result(got);
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
            $display("FAIL hold_result: got q=%h r=%h dz=%b ovf=%b, want q=%h r=%h dz=%b ovf=%b",
                     got.q, got.r, got.dz, got.ovf, exp.q, exp.r, exp.dz, exp.ovf);
        end else passes++;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            $display("FAIL hold_no_capture: got ov=%b ir=%b, want ov=0 ir=1", bus.out_valid, bus.in_ready);
        end else passes++;
    endtask

    task automatic test_reset_mid();
        int   lat;
        bit   to;
        res_t got, exp;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.c        = 128'd123456789 * 128'd1001 + 128'd17;
        bus.b        = 64'd1001;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            $display("FAIL mid_busy: got ir=%b ov=%b, want ir=0 ov=0", bus.in_ready, bus.out_valid);
        end else passes++;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.q !== '0 || bus.r !== '0 || bus.div_zero !== 1'b0 ||
            bus.ovf !== 1'b0 || bus.in_ready !== 1'b1) begin
            $display("FAIL mid_reset: got ov=%b q=%h r=%h dz=%b ovf=%b ir=%b, want zeros and ir=1",
                     bus.out_valid, bus.q, bus.r, bus.div_zero, bus.ovf, bus.in_ready);
        end else passes++;
        @(negedge clk);
        rst = 1'b1;
        sb.push_back('{q: 64'd14, r: 64'd2, dz: 1'b0, ovf: 1'b0});
        run_op(128'd100, 64'd7, lat, to);
        checks++;
        if (to || lat != A + 1) begin
            $display("FAIL post_reset_latency: got %0d (timeout=%0d), want %0d", lat, to, A + 1);
        end else passes++;
        take_result(got);
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
            $display("FAIL post_reset_result: got q=%h r=%h dz=%b ovf=%b, want q=%h r=%h dz=%b ovf=%b",
                     got.q, got.r, got.dz, got.ovf, exp.q, exp.r, exp.dz, exp.ovf);
        end else passes++;
    endtask

    task automatic test_random(input int n);
        int   lat;
        bit   to;
        res_t got, exp;
        logic [A-1:0]   av;
        logic [B-1:0]   bv, rv;
        logic [A+B-1:0] cv;
        for (int i = 0; i < n; i++) begin
            av = {$urandom, $urandom};
            case ($urandom_range(0, 2))
                0:       bv = {$urandom, $urandom};
                1:       bv = {32'd0, $urandom};
                default: bv = 64'($urandom_range(1, 16));
            endcase
            if (bv == '0) bv = 64'd1;
            rv = {$urandom, $urandom};
            rv = rv % bv;
            cv = {64'd0, av} * {64'd0, bv} + {64'd0, rv};
            sb.push_back('{q: av, r: rv, dz: 1'b0, ovf: 1'b0});
            run_op(cv, bv, lat, to);
            checks++;
            if (to || lat != A + 1) begin
                $display("FAIL rand_latency[%0d]: got %0d (timeout=%0d), want %0d", i, lat, to, A + 1);
            end else passes++;
            if (!to) begin
                take_result(got);
                exp = sb.pop_front();
                checks++;
                if (got !== exp) begin
                    $display("FAIL rand_result[%0d]: c=%h b=%h got q=%h r=%h dz=%b ovf=%b, want q=%h r=%h",
                             i, cv, bv, got.q, got.r, got.dz, got.ovf, exp.q, exp.r);
                end else passes++;
            end else begin
                void'(sb.pop_front());
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_ovf();
        test_div_zero();
        test_hold();
        test_reset_mid();
        test_random(300);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
